// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO pointer helpers and default constants
package fifo_pkg;
  localparam int PTR_BITS_DEF = 4;
  localparam int SYNC_STAGES_DEF = 2;
  // Zero-extended operands convert correctly, so callers cast their width to/from 32
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < 32; i++) b[i] = ^(g >> i);
    return b;
  endfunction
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/sync_chain.sv
// sync_chain: STAGES-deep multi-bit metastability flop chain with async active-low reset
module sync_chain #(
  parameter int WIDTH = 1,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [STAGES-1:0][WIDTH-1:0] r_q;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_q <= '0;
    else          r_q <= {r_q[STAGES-2:0], i_d};
  assign o_q = r_q[STAGES-1];
endmodule

// File: rtl/gray_ptr_sync.sv
// gray_ptr_sync: Gray pointer synchroniser with binary conversion, advance, jump check and flush-valid
module gray_ptr_sync
  import fifo_pkg::*;
#(
  parameter int NUM_BITS = PTR_BITS_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int MAX_STEP = 1
) (
  input  logic                rd_clk,
  input  logic                rd_rst,
  input  logic [NUM_BITS-1:0] ptr_gray_async,
  input  logic                err_clr,
  output logic [NUM_BITS-1:0] ptr_gray_sync,
  output logic [NUM_BITS-1:0] ptr_bin_sync,
  output logic [NUM_BITS-1:0] ptr_delta,
  output logic                ptr_changed,
  output logic                gray_err,
  output logic                sync_valid
);
  localparam int CW = clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(SYNC_STAGES + 1);
  localparam logic [NUM_BITS-1:0] MAX_D = NUM_BITS'(MAX_STEP);
  logic [NUM_BITS-1:0] w_gs, w_bin, w_delta;
  logic [CW-1:0]       r_cnt;
  logic                w_err;
  sync_chain #(.WIDTH(NUM_BITS), .STAGES(SYNC_STAGES)) u_chain (
    .i_clk  (rd_clk),
    .i_rst_n(rd_rst),
    .i_d    (ptr_gray_async),
    .o_q    (w_gs)
  );
  always_comb begin
    w_bin   = NUM_BITS'(gray2bin(32'(w_gs)));
    w_delta = w_bin - ptr_bin_sync;
    w_err   = sync_valid && (w_delta > MAX_D);
  end
  // sync_valid is registered off the saturated count, so it rises one edge after saturation
  always_ff @(posedge rd_clk or negedge rd_rst)
    if (!rd_rst) begin
      ptr_gray_sync <= '0;
      ptr_bin_sync  <= '0;
      ptr_delta     <= '0;
      ptr_changed   <= 1'b0;
      gray_err      <= 1'b0;
      sync_valid    <= 1'b0;
      r_cnt         <= '0;
    end else begin
      ptr_gray_sync <= w_gs;
      ptr_bin_sync  <= w_bin;
      ptr_delta     <= w_delta;
      ptr_changed   <= w_gs != ptr_gray_sync;
      gray_err      <= w_err ? 1'b1 : (err_clr ? 1'b0 : gray_err);
      sync_valid    <= r_cnt == CNT_MAX;
      r_cnt         <= (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    end
endmodule

// File: doc/gray_ptr_sync.md
# gray_ptr_sync

Parametrised multi-stage synchroniser that carries a Gray-coded FIFO pointer from the write domain into the read domain. It converts the synchronised pointer to binary and reports the per-cycle pointer advance. It also flags illegal jumps and asserts a valid indication once the synchroniser chain has flushed after reset. It replaces the fixed two-flop pointer synchroniser in the async FIFO and can be instantiated in either direction.

## Interface
- NUM_BITS, 4: pointer width in bits, including the wrap bit; legal range is 2 or more.
- SYNC_STAGES, 2: number of metastability flops; legal range is 2 to 4.
- MAX_STEP, 1: largest legal pointer advance between consecutive synchronised samples; legal range is 1 to 2^(NUM_BITS-1).
- rd_clk, input, 1: destination clock. This is the block's only clock; the reset is asynchronous and active-low.
- rd_rst, input, 1: asynchronous active-low reset. Assertion is asynchronous; release is expected synchronous to rd_clk.
- ptr_gray_async, input, NUM_BITS: Gray pointer from the source domain, which is treated as fully asynchronous.
- err_clr, input, 1: synchronous clear for gray_err.
- ptr_gray_sync, output, NUM_BITS: synchronised Gray pointer.
- ptr_bin_sync, output, NUM_BITS: binary equivalent of ptr_gray_sync.
- ptr_delta, output, NUM_BITS: advance since the previous cycle, computed modulo 2^NUM_BITS.
- ptr_changed, output, 1: single-cycle pulse when ptr_gray_sync changes.
- gray_err, output, 1: sticky flag, set when the advance exceeds MAX_STEP.
- sync_valid, output, 1: 0 until the chain has flushed after reset, then 1.

## Operation
- **Sync chain:** SYNC_STAGES flops of NUM_BITS each. Stage 0 samples ptr_gray_async; stage i samples stage i-1. The last stage is called g_s.
- **Output register:** on each rd_clk edge, load ptr_gray_sync from g_s and ptr_bin_sync from gray2bin(g_s).
  - Gray-to-binary conversion: b[N-1] = g[N-1]; b[i] = b[i+1] ^ g[i].
- **Delta:** ptr_delta is registered as gray2bin(g_s) minus the current ptr_bin_sync, modulo 2^NUM_BITS. Wrap-around is therefore seamless: 15 to 0 gives a delta of 1 for 4 bits.
- **Change pulse:** ptr_changed is registered as (g_s != ptr_gray_sync).
- **Error flag:**
  - gray_err sets when the newly computed delta is greater than MAX_STEP and sync_valid is 1.
  - It holds until err_clr or reset.
  - If err_clr and a new error occur in the same cycle, set wins and gray_err stays 1.
- **Valid counter:**
  - A counter of width clog2(SYNC_STAGES+2) counts from 0 up to SYNC_STAGES+1 after reset release, then saturates.
  - sync_valid = 1 when the counter is saturated.
  - Error detection is suppressed while sync_valid = 0.
- **Reset values:** all flops reset to 0. This gives ptr_gray_sync = 0, ptr_bin_sync = 0, ptr_delta = 0, ptr_changed = 0, gray_err = 0 and sync_valid = 0.
- **Reset mid-operation:**
  - All state clears immediately, without waiting for a clock edge.
  - sync_valid drops and re-runs its full count after release.
  - A pointer held non-zero across reset reappears as a jump from 0. That jump is not flagged, because sync_valid is still 0.
- No combinational path exists from any input to any output.

## Timing
- **Latency:** a stable change on ptr_gray_async that is captured at rd_clk edge k appears on ptr_gray_sync, ptr_bin_sync, ptr_delta and ptr_changed after edge k+SYNC_STAGES. Capture may slip by one edge because of metastability.
- **Alignment:** ptr_delta, ptr_changed and ptr_bin_sync are cycle-aligned with ptr_gray_sync.
- **gray_err:** asserts in the same cycle as the offending ptr_delta. It clears on the edge after err_clr is sampled high.
- **sync_valid:** rises at the (SYNC_STAGES+2)-th rd_clk edge after rd_rst is released.
- **ptr_changed:** high for exactly one cycle per distinct new value. It stays low while the pointer is unchanged.

## Structure
- Shared package (fifo_pkg) holds:
  - the gray2bin and bin2gray functions, shared with the pointer generators;
  - a clog2 helper function;
  - the default constants PTR_BITS_DEF = 4 and SYNC_STAGES_DEF = 2.
- One natural sub-module, sync_chain: a parametrised SYNC_STAGES-deep flop chain with width and reset. It is reusable for single-bit flag synchronisation elsewhere in the FIFO.
- The top level contains sync_chain, the output register, the delta and error logic, and the valid counter.
- Expected size is about 150 to 200 lines of RTL.

## Test plan
1. **Reset and valid:** assert rd_rst, then release it with SYNC_STAGES = 2. All outputs are 0 during reset; sync_valid rises at the 4th edge after release.
2. **Latency:** drive ptr_gray_async = 4'b0111 (binary 5) stable. ptr_gray_sync = 0111, ptr_bin_sync = 0101 and ptr_changed = 1 for one cycle, appearing SYNC_STAGES edges after capture. Repeat with SYNC_STAGES = 3 and check one extra cycle of latency.
3. **Wrap-around:** step the pointer through Gray values for binary 14, 15 and 0 (1001, 1000, 0000), holding each for 3 cycles. ptr_delta = 1 on each change with no gray_err, and ptr_bin_sync goes 14, 15, 0.
4. **Illegal jump:** with MAX_STEP = 1 and sync_valid = 1, jump from Gray 0000 to 0101 (binary 6). ptr_delta = 6 and gray_err = 1, staying set across further legal steps. Pulse err_clr and check gray_err = 0 on the next edge.
5. **Simultaneous set and clear:** assert err_clr in the same cycle an illegal jump is registered. gray_err remains 1.
6. **Reset mid-operation:** with the pointer at binary 9, assert rd_rst asynchronously between clock edges. Outputs go to 0 immediately. After release, the reappearance of binary 9 gives no gray_err, and sync_valid re-runs its count.
